// File: rtl/ramb_porta_arbiter_pkg.sv
// Shared block-RAM geometry and requester encoding used by the port-A arbiter,
// the RAM wrapper and the streaming reader.
package ramb_porta_arbiter_pkg;

  localparam int RAM_DATA_W = 16;
  localparam int RAM_PAR_W  = 2;
  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DEPTH  = 1024;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_idx_e;

  function automatic req_idx_e other_req(input req_idx_e idx);
    return (idx == REQ_0) ? REQ_1 : REQ_0;
  endfunction

endpackage

// File: rtl/ramb_porta_arbiter_rr_arb2.sv
// Two-way round-robin grant with burst locking; purely combinational, the
// caller holds the arbitration registers and feeds back the *_nxt values.
module rr_arb2 import ramb_porta_arbiter_pkg::*; #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  req_idx_e         last,
  input  logic             owner_valid,
  input  req_idx_e         owner,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [1:0]       gnt,
  output logic             accept,
  output req_idx_e         winner,
  output req_idx_e         last_nxt,
  output logic             owner_valid_nxt,
  output req_idx_e         owner_nxt,
  output logic [CNT_W-1:0] burst_cnt_nxt
);

  // Counter stops at MAX_BURST-1 so a lone locked requester cannot wrap it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (int'(cnt) >= MAX_BURST - 1) return cnt;
    return cnt + 1'b1;
  endfunction

  logic hold;

  always_comb begin
    hold   = owner_valid && (int'(burst_cnt) < MAX_BURST - 1);
    accept = 1'b0;
    winner = REQ_0;
    if (!rst) begin
      unique case (req)
        2'b01: begin
          accept = 1'b1;
          winner = REQ_0;
        end
        2'b10: begin
          accept = 1'b1;
          winner = REQ_1;
        end
        2'b11: begin
          accept = 1'b1;
          if (owner_valid) winner = hold ? owner : other_req(owner);
          else             winner = other_req(last);
        end
        default: accept = 1'b0;
      endcase
    end
    gnt = 2'b00;
    if (accept) gnt = (winner == REQ_1) ? 2'b10 : 2'b01;
  end

  always_comb begin
    last_nxt        = last;
    owner_valid_nxt = owner_valid;
    owner_nxt       = owner;
    burst_cnt_nxt   = burst_cnt;
    // An owner that stops requesting gives up its lock immediately.
    if (owner_valid && !req[owner]) begin
      owner_valid_nxt = 1'b0;
      burst_cnt_nxt   = '0;
    end
    if (accept) begin
      last_nxt = winner;
      if (lock[winner]) begin
        owner_valid_nxt = 1'b1;
        owner_nxt       = winner;
        burst_cnt_nxt   = (owner_valid && owner == winner) ? sat_inc(burst_cnt) : '0;
      end else begin
        owner_valid_nxt = 1'b0;
        burst_cnt_nxt   = '0;
      end
    end
  end

endmodule

// File: rtl/ramb_porta_arbiter.sv
// Shares RAMB16 port A between two masters: round-robin grant, registered RAM
// command, and a tagged two-stage read-return pipeline.
module ramb_porta_arbiter import ramb_porta_arbiter_pkg::*; #(
  parameter int DATA_WIDTH = RAM_DATA_W,
  parameter int PAR_WIDTH  = RAM_PAR_W,
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int MAX_BURST  = 4
) (
  input  logic                  CLK,
  input  logic                  SSR,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  LOCK0,
  input  logic                  LOCK1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DI0,
  input  logic [DATA_WIDTH-1:0] DI1,
  input  logic [PAR_WIDTH-1:0]  DIP0,
  input  logic [PAR_WIDTH-1:0]  DIP1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  VALID0,
  output logic                  VALID1,
  output logic [DATA_WIDTH-1:0] DO0,
  output logic [DATA_WIDTH-1:0] DO1,
  output logic [PAR_WIDTH-1:0]  DOP0,
  output logic [PAR_WIDTH-1:0]  DOP1,
  output logic                  ENA,
  output logic                  WEA,
  output logic [ADDR_WIDTH-1:0] ADDRA,
  output logic [DATA_WIDTH-1:0] DIA,
  output logic [PAR_WIDTH-1:0]  DIPA,
  input  logic [DATA_WIDTH-1:0] DOA,
  input  logic [PAR_WIDTH-1:0]  DOPA
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  req_idx_e         last, last_nxt, owner, owner_nxt, winner;
  logic             owner_valid, owner_valid_nxt, accept;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [1:0]       gnt;

  rr_arb2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_arb (
    .rst             (SSR),
    .req             ({REQ1, REQ0}),
    .lock            ({LOCK1, LOCK0}),
    .last            (last),
    .owner_valid     (owner_valid),
    .owner           (owner),
    .burst_cnt       (burst_cnt),
    .gnt             (gnt),
    .accept          (accept),
    .winner          (winner),
    .last_nxt        (last_nxt),
    .owner_valid_nxt (owner_valid_nxt),
    .owner_nxt       (owner_nxt),
    .burst_cnt_nxt   (burst_cnt_nxt)
  );

  assign GNT0 = gnt[0];
  assign GNT1 = gnt[1];

  // last resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or posedge SSR) begin
    if (SSR) begin
      last        <= REQ_1;
      owner       <= REQ_0;
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      last        <= last_nxt;
      owner       <= owner_nxt;
      owner_valid <= owner_valid_nxt;
      burst_cnt   <= burst_cnt_nxt;
    end
  end

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_di;
  logic [PAR_WIDTH-1:0]  sel_dip;

  always_comb begin
    sel_we   = WE0;
    sel_addr = ADDR0;
    sel_di   = DI0;
    sel_dip  = DIP0;
    if (winner == REQ_1) begin
      sel_we   = WE1;
      sel_addr = ADDR1;
      sel_di   = DI1;
      sel_dip  = DIP1;
    end
  end

  logic                  en_p0, we_p0, vld_p0, vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] di_p0;
  logic [PAR_WIDTH-1:0]  dip_p0;
  req_idx_e              tag_p0, tag_p1;

  // Stage p0: RAM command register; stage p1: aligns the tag with RAM read data.
  always_ff @(posedge CLK or posedge SSR) begin
    if (SSR) begin
      en_p0   <= 1'b0;
      we_p0   <= 1'b0;
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      di_p0   <= '0;
      dip_p0  <= '0;
      tag_p0  <= REQ_0;
      vld_p1  <= 1'b0;
      tag_p1  <= REQ_0;
    end else begin
      en_p0  <= accept;
      we_p0  <= accept & sel_we;
      vld_p0 <= accept & ~sel_we;
      if (accept) begin
        addr_p0 <= sel_addr;
        di_p0   <= sel_di;
        dip_p0  <= sel_dip;
        tag_p0  <= winner;
      end
      vld_p1 <= vld_p0;
      tag_p1 <= tag_p0;
    end
  end

  assign ENA   = en_p0;
  assign WEA   = we_p0;
  assign ADDRA = addr_p0;
  assign DIA   = di_p0;
  assign DIPA  = dip_p0;

  assign VALID0 = vld_p1 && (tag_p1 == REQ_0);
  assign VALID1 = vld_p1 && (tag_p1 == REQ_1);
  assign DO0    = VALID0 ? DOA  : '0;
  assign DOP0   = VALID0 ? DOPA : '0;
  assign DO1    = VALID1 ? DOA  : '0;
  assign DOP1   = VALID1 ? DOPA : '0;

endmodule

// File: tb/tb_ramb_porta_arbiter.sv
// Bench for ramb_porta_arbiter: behavioural RAM on port A plus a transaction-level
// model of grants, command register and tagged read returns.
module tb_ramb_porta_arbiter;
  import ramb_porta_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int PW = 2;
  localparam int AW = 10;
  localparam int MB = 4;

  logic CLK = 1'b0;
  logic SSR = 1'b1;
  logic REQ0 = 0, REQ1 = 0, LOCK0 = 0, LOCK1 = 0, WE0 = 0, WE1 = 0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [DW-1:0] DI0 = '0, DI1 = '0;
  logic [PW-1:0] DIP0 = '0, DIP1 = '0;
  logic GNT0, GNT1, VALID0, VALID1, ENA, WEA;
  logic [DW-1:0] DO0, DO1, DIA;
  logic [PW-1:0] DOP0, DOP1, DIPA;
  logic [AW-1:0] ADDRA;
  logic [DW-1:0] DOA = '0;
  logic [PW-1:0] DOPA = '0;

  always #5 CLK = ~CLK;

  ramb_porta_arbiter #(.DATA_WIDTH(DW), .PAR_WIDTH(PW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .SSR(SSR), .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .WE0(WE0), .WE1(WE1), .ADDR0(ADDR0), .ADDR1(ADDR1), .DI0(DI0), .DI1(DI1),
    .DIP0(DIP0), .DIP1(DIP1), .GNT0(GNT0), .GNT1(GNT1), .VALID0(VALID0), .VALID1(VALID1),
    .DO0(DO0), .DO1(DO1), .DOP0(DOP0), .DOP1(DOP1), .ENA(ENA), .WEA(WEA), .ADDRA(ADDRA),
    .DIA(DIA), .DIPA(DIPA), .DOA(DOA), .DOPA(DOPA)
  );

  // Port-A RAM, write-first, one-cycle read latency.
  logic [PW+DW-1:0] ram [0:1023];
  always @(posedge CLK) begin
    if (ENA) begin
      if (WEA) begin
        ram[ADDRA]   <= {DIPA, DIA};
        {DOPA, DOA}  <= {DIPA, DIA};
      end else begin
        {DOPA, DOA}  <= ram[ADDRA];
      end
    end
  end

  // Reference model state
  typedef struct {int due; int who; logic [PW+DW-1:0] word;} ret_t;
  ret_t             rq[$];
  logic [PW+DW-1:0] shadow [0:1023];
  logic [29:0]      m_cmd;
  int m_last, m_owner, m_run, cyc;
  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_run = 0; m_cmd = '0;
    rq.delete();
  endtask

  function automatic logic [37:0] act_ret();
    return {VALID1, VALID0, DOP1, DO1, DOP0, DO0};
  endfunction

  function automatic logic [29:0] act_cmd();
    return {ENA, WEA, ADDRA, DIA, DIPA};
  endfunction

  // Settles the inputs, then yields what the outputs must be this cycle and
  // advances the model by one accept decision.
  task automatic predict(output logic [1:0] eg, output logic [37:0] eret, output logic [29:0] ecmd);
    int g;
    ret_t h;
    logic we;
    logic [AW-1:0] a;
    logic [PW+DW-1:0] wd;
    #1;
    ecmd = m_cmd;
    eret = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      h = rq.pop_front();
      if (h.who == 0) eret = {2'b01, 18'h0, h.word};
      else            eret = {2'b10, h.word, 18'h0};
    end
    g = -1;
    if (!SSR) begin
      if (REQ0 && !REQ1)      g = 0;
      else if (REQ1 && !REQ0) g = 1;
      else if (REQ0 && REQ1) begin
        if (m_owner >= 0) g = (m_run < MB) ? m_owner : 1 - m_owner;
        else              g = 1 - m_last;
      end
    end
    eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    if ((m_owner == 0 && !REQ0) || (m_owner == 1 && !REQ1)) begin
      m_owner = -1; m_run = 0;
    end
    m_cmd[29:28] = 2'b00;
    if (g >= 0) begin
      we = (g == 1) ? WE1 : WE0;
      a  = (g == 1) ? ADDR1 : ADDR0;
      wd = (g == 1) ? {DIP1, DI1} : {DIP0, DI0};
      m_last = g;
      if ((g == 1) ? LOCK1 : LOCK0) begin
        m_run   = (m_owner == g) ? m_run + 1 : 1;
        m_owner = g;
      end else begin
        m_owner = -1; m_run = 0;
      end
      m_cmd = {1'b1, we, a, wd[DW-1:0], wd[DW+PW-1:DW]};
      if (we) shadow[a] = wd;
      else    rq.push_back('{cyc + 2, g, shadow[a]});
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle();
    REQ0 = 0; REQ1 = 0; LOCK0 = 0; LOCK1 = 0; WE0 = 0; WE1 = 0;
  endtask

  task automatic test_reset();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    SSR = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    REQ0 = 1; REQ1 = 1;
    model_reset();
    predict(eg, eret, ecmd);
    checks++; if ({GNT1, GNT0} !== 2'b00) begin errors++; $display("FAIL rst_gnt got=%b want=00", {GNT1, GNT0}); end
    checks++; if (act_ret() !== 38'h0) begin errors++; $display("FAIL rst_ret got=%h want=0", act_ret()); end
    checks++; if (act_cmd() !== 30'h0) begin errors++; $display("FAIL rst_cmd got=%h want=0", act_cmd()); end
    SSR = 1'b0;
    idle();
    step();
  endtask

  task automatic test_write_read();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin REQ0 = 1; WE0 = 1; ADDR0 = 10'h005; DI0 = 16'h1234; DIP0 = 2'h1; end
      if (c == 1) begin REQ1 = 1; WE1 = 0; ADDR1 = 10'h005; end
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL wr_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      checks++; if (act_ret() !== eret) begin errors++; $display("FAIL wr_ret cyc=%0d got=%h want=%h", cyc, act_ret(), eret); end
      checks++; if (act_cmd() !== ecmd) begin errors++; $display("FAIL wr_cmd cyc=%0d got=%h want=%h", cyc, act_cmd(), ecmd); end
      if (c == 0) begin
        checks++; if (GNT0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0 got=%b want=1", GNT0); end
      end
      if (c == 3) begin
        checks++;
        if ({VALID1, DO1, DOP1, VALID0} !== {1'b1, 16'h1234, 2'h1, 1'b0}) begin
          errors++; $display("FAIL wr_readback got=%b/%h/%h v0=%b want=1/1234/1 v0=0", VALID1, DO1, DOP1, VALID0);
        end
      end
      step();
    end
  endtask

  task automatic test_alternate();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    int n0, n1;
    for (int i = 0; i < 8; i++) begin
      idle();
      REQ1 = 1; WE1 = 1; ADDR1 = AW'(32 + i); DI1 = DW'(16'hA000 + i * 257); DIP1 = PW'(i);
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL pre_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      step();
    end
    n0 = 0; n1 = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 8) begin
        REQ0 = 1; ADDR0 = AW'(32 + n0);
        REQ1 = 1; ADDR1 = AW'(36 + n1);
      end
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL alt_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      checks++; if (act_ret() !== eret) begin errors++; $display("FAIL alt_ret cyc=%0d got=%h want=%h", cyc, act_ret(), eret); end
      if (c < 8) begin
        checks++; if ({GNT1, GNT0} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_order c=%0d got=%b", c, {GNT1, GNT0}); end
      end
      if (c >= 2) begin
        checks++; if ({VALID1, VALID0} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL alt_valid c=%0d got=%b", c, {VALID1, VALID0}); end
      end
      if (eg[0]) n0++;
      if (eg[1]) n1++;
      step();
    end
  endtask

  task automatic test_burst();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    logic [1:0] pattern [0:5];
    pattern = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c < 6) begin
        REQ0 = 1; LOCK0 = 1; ADDR0 = AW'(32 + c);
        REQ1 = 1; LOCK1 = 0; ADDR1 = AW'(40 - c);
      end
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL bst_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      checks++; if (act_ret() !== eret) begin errors++; $display("FAIL bst_ret cyc=%0d got=%h want=%h", cyc, act_ret(), eret); end
      if (c < 6) begin
        checks++; if ({GNT1, GNT0} !== pattern[c]) begin errors++; $display("FAIL bst_pattern c=%0d got=%b want=%b", c, {GNT1, GNT0}, pattern[c]); end
      end
      step();
    end
  endtask

  task automatic test_raw_top();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin REQ1 = 1; WE1 = 1; ADDR1 = 10'h3FF; DI1 = 16'hBEEF; DIP1 = 2'h2; end
      if (c == 1) begin REQ0 = 1; WE0 = 0; ADDR0 = 10'h3FF; end
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL raw_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      checks++; if (act_ret() !== eret) begin errors++; $display("FAIL raw_ret cyc=%0d got=%h want=%h", cyc, act_ret(), eret); end
      checks++; if (act_cmd() !== ecmd) begin errors++; $display("FAIL raw_cmd cyc=%0d got=%h want=%h", cyc, act_cmd(), ecmd); end
      if (c == 3) begin
        checks++; if ({VALID0, DO0, DOP0} !== {1'b1, 16'hBEEF, 2'h2}) begin errors++; $display("FAIL raw_data got=%b/%h/%h want=1/beef/2", VALID0, DO0, DOP0); end
      end
      step();
    end
  endtask

  task automatic test_reset_midread();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin REQ1 = 1; ADDR1 = 10'h005; end
      if (c == 1) begin SSR = 1'b1; REQ0 = 1; REQ1 = 1; model_reset(); end
      if (c == 2) begin SSR = 1'b0; REQ0 = 1; ADDR0 = 10'h3FF; REQ1 = 1; ADDR1 = 10'h005; end
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL mrst_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      checks++; if (act_ret() !== eret) begin errors++; $display("FAIL mrst_ret cyc=%0d got=%h want=%h", cyc, act_ret(), eret); end
      checks++; if (act_cmd() !== ecmd) begin errors++; $display("FAIL mrst_cmd cyc=%0d got=%h want=%h", cyc, act_cmd(), ecmd); end
      if (c == 1) begin
        checks++; if ({GNT1, GNT0, act_ret(), act_cmd()} !== 70'h0) begin errors++; $display("FAIL mrst_zero got=%b/%h/%h", {GNT1, GNT0}, act_ret(), act_cmd()); end
      end
      if (c == 2) begin
        checks++; if ({GNT1, GNT0, VALID1} !== 3'b010) begin errors++; $display("FAIL mrst_first got gnt=%b v1=%b want gnt=01 v1=0", {GNT1, GNT0}, VALID1); end
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [1:0] eg; logic [37:0] eret; logic [29:0] ecmd;
    bit pend [2];
    logic we_r [2];
    logic [AW-1:0] ad_r [2];
    logic [DW-1:0] di_r [2];
    logic [PW-1:0] dp_r [2];
    pend = '{0, 0};
    for (int c = 0; c < 603; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && c < 600 && $urandom_range(0, 3) != 0) begin
          pend[x] = 1;
          we_r[x] = 1'($urandom_range(0, 1));
          ad_r[x] = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
          di_r[x] = DW'($urandom);
          dp_r[x] = PW'($urandom);
        end
      end
      REQ0 = pend[0]; WE0 = we_r[0]; ADDR0 = ad_r[0]; DI0 = di_r[0]; DIP0 = dp_r[0];
      REQ1 = pend[1]; WE1 = we_r[1]; ADDR1 = ad_r[1]; DI1 = di_r[1]; DIP1 = dp_r[1];
      LOCK0 = 1'($urandom_range(0, 2) != 0);
      LOCK1 = 1'($urandom_range(0, 2) != 0);
      predict(eg, eret, ecmd);
      checks++; if ({GNT1, GNT0} !== eg) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, {GNT1, GNT0}, eg); end
      checks++; if (act_ret() !== eret) begin errors++; $display("FAIL rnd_ret cyc=%0d got=%h want=%h", cyc, act_ret(), eret); end
      checks++; if (act_cmd() !== ecmd) begin errors++; $display("FAIL rnd_cmd cyc=%0d got=%h want=%h", cyc, act_cmd(), ecmd); end
      if (eg[0]) pend[0] = 0;
      if (eg[1]) pend[1] = 0;
      step();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    for (int x = 0; x < 1; x++) cyc = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_alternate();
    test_burst();
    test_raw_top();
    test_reset_midread();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
